// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - MEM-stage load/store sequencer for a single-byte-port 256x8 data RAM
module mem_byte_sequencer #(
  parameter int ADDR_W     = 8,
  parameter bit ALIGN_WORD = 1'b1
) (
  input  logic              clk,
  input  logic              R,
  input  logic              E,
  input  logic              RW,
  input  logic              Size,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       DI,
  input  logic [7:0]        ram_DO,
  output logic              ram_E,
  output logic              ram_RW,
  output logic [ADDR_W-1:0] ram_A,
  output logic [7:0]        ram_DI,
  output logic [31:0]       DO,
  output logic              stall,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_di;
  logic              r_rw;
  logic              r_size;
  logic [31:0]       r_do;

  logic              w_last;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wbyte;

  // Word requests may be snapped to a 4-byte boundary; byte requests always use A as-is.
  always_comb begin
    w_base = A;
    if (Size && ALIGN_WORD) begin
      w_base = {A[ADDR_W-1:2], 2'b00};
    end
  end

  // Current byte address (wraps naturally at 2^ADDR_W), last-byte flag and store byte lane (big-endian).
  always_comb begin
    w_addr  = r_base + ADDR_W'(r_cnt);
    w_last  = r_size ? (r_cnt == 2'd3) : 1'b1;
    w_wbyte = r_di[7:0];
    if (r_size) begin
      case (r_cnt)
        2'd0:    w_wbyte = r_di[31:24];
        2'd1:    w_wbyte = r_di[23:16];
        2'd2:    w_wbyte = r_di[15:8];
        default: w_wbyte = r_di[7:0];
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and RAM/pipeline handshake outputs; stall follows E combinationally in IDLE.
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    done   = 1'b0;
    ram_E  = 1'b0;
    ram_RW = 1'b0;
    ram_A  = '0;
    ram_DI = '0;
    case (r_state)
      S_IDLE: begin
        stall = E;
        if (E) begin
          w_next = S_XFER;
        end
      end
      S_XFER: begin
        stall  = 1'b1;
        ram_E  = 1'b1;
        ram_RW = r_rw;
        ram_A  = w_addr;
        ram_DI = w_wbyte;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch, byte counter and load-data assembly; request inputs are ignored once latched.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_cnt  <= 2'd0;
      r_base <= '0;
      r_di   <= '0;
      r_rw   <= 1'b0;
      r_size <= 1'b0;
      r_do   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (E) begin
            r_cnt  <= 2'd0;
            r_base <= w_base;
            r_di   <= DI;
            r_rw   <= RW;
            r_size <= Size;
          end
        end
        S_XFER: begin
          if (!r_rw) begin
            if (r_size) begin
              case (r_cnt)
                2'd0:    r_do[31:24] <= ram_DO;
                2'd1:    r_do[23:16] <= ram_DO;
                2'd2:    r_do[15:8]  <= ram_DO;
                default: r_do[7:0]   <= ram_DO;
              endcase
            end else begin
              r_do <= {24'b0, ram_DO};
            end
          end
          if (w_last) begin
            r_cnt <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: begin
          r_cnt <= 2'd0;
        end
      endcase
    end
  end

  assign DO = r_do;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - scoreboard bench: aligned and unaligned sequencers against a byte-array model
module tb_mem_byte_sequencer;

  logic        clk = 1'b0;
  logic        R;
  logic        E;
  logic        RW;
  logic        Size;
  logic [7:0]  A;
  logic [31:0] DI;

  logic        ram_E0, ram_RW0, stall0, done0;
  logic [7:0]  ram_A0, ram_DI0, ram_DO0;
  logic [31:0] DO0;
  logic        ram_E1, ram_RW1, stall1, done1;
  logic [7:0]  ram_A1, ram_DI1, ram_DO1;
  logic [31:0] DO1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  bit   [7:0] rm   [2][256];
  bit   [31:0] ref_do [2];

  // {rw, addr, data} per byte access; {lat, do} per completed operation
  bit [16:0] qacc0 [$];
  bit [16:0] qacc1 [$];
  bit [39:0] qres0 [$];
  bit [39:0] qres1 [$];

  int errors = 0;
  int checks = 0;
  int sc [2];
  int dc [2];
  int nops = 0;

  always #5 clk = ~clk;

  mem_byte_sequencer #(.ADDR_W(8), .ALIGN_WORD(1'b1)) dut0 (
    .clk(clk), .R(R), .E(E), .RW(RW), .Size(Size), .A(A), .DI(DI),
    .ram_DO(ram_DO0), .ram_E(ram_E0), .ram_RW(ram_RW0), .ram_A(ram_A0),
    .ram_DI(ram_DI0), .DO(DO0), .stall(stall0), .done(done0)
  );

  mem_byte_sequencer #(.ADDR_W(8), .ALIGN_WORD(1'b0)) dut1 (
    .clk(clk), .R(R), .E(E), .RW(RW), .Size(Size), .A(A), .DI(DI),
    .ram_DO(ram_DO1), .ram_E(ram_E1), .ram_RW(ram_RW1), .ram_A(ram_A1),
    .ram_DI(ram_DI1), .DO(DO1), .stall(stall1), .done(done1)
  );

  assign ram_DO0 = mem0[ram_A0];
  assign ram_DO1 = mem1[ram_A1];

  always @(posedge clk) begin
    if (ram_E0 && ram_RW0) mem0[ram_A0] <= ram_DI0;
    if (ram_E1 && ram_RW1) mem1[ram_A1] <= ram_DI1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: expand one request into byte accesses for dut k; limit < n models an interrupted op.
  task automatic model(input int k, input bit rw, input bit size, input bit [7:0] a,
                       input bit [31:0] di, input int limit);
    bit [7:0]  base;
    bit [7:0]  addr;
    bit [7:0]  data;
    bit [31:0] rd;
    int        n;
    base = (size && k == 0) ? (a & 8'hFC) : a;
    n    = size ? 4 : 1;
    rd   = 0;
    for (int i = 0; i < n && i < limit; i++) begin
      addr = base + 8'(i);
      data = size ? 8'(di >> (8 * (3 - i))) : di[7:0];
      if (rw) rm[k][addr] = data;
      else    rd = (rd << 8) | 32'(rm[k][addr]);
      if (k == 0) qacc0.push_back({rw, addr, rw ? data : 8'h00});
      else        qacc1.push_back({rw, addr, rw ? data : 8'h00});
    end
    if (limit >= n) begin
      if (!rw) ref_do[k] = rd;
      if (k == 0) qres0.push_back({8'(size ? 5 : 2), ref_do[k]});
      else        qres1.push_back({8'(size ? 5 : 2), ref_do[k]});
    end
  endtask

  task automatic mon(input int k, input logic e, input logic rw, input logic [7:0] ad,
                     input logic [7:0] wd, input logic dn, input logic [31:0] dout, input logic st);
    bit [16:0] ea;
    bit [39:0] er;
    bit        ok;
    if (st) sc[k]++;
    if (e) begin
      ok = (k == 0) ? (qacc0.size() > 0) : (qacc1.size() > 0);
      if (!ok) begin
        check($sformatf("unexpected_access%0d", k), {23'b0, rw, ad}, 32'hFFFF_FFFF);
      end else begin
        ea = (k == 0) ? qacc0.pop_front() : qacc1.pop_front();
        check($sformatf("ram_A%0d", k), {24'b0, ad}, {24'b0, ea[15:8]});
        check($sformatf("ram_RW%0d", k), {31'b0, rw}, {31'b0, ea[16]});
        if (ea[16]) check($sformatf("ram_DI%0d", k), {24'b0, wd}, {24'b0, ea[7:0]});
      end
    end
    if (dn) begin
      dc[k]++;
      ok = (k == 0) ? (qres0.size() > 0) : (qres1.size() > 0);
      if (!ok) begin
        check($sformatf("unexpected_done%0d", k), 32'd1, 32'd0);
      end else begin
        er = (k == 0) ? qres0.pop_front() : qres1.pop_front();
        check($sformatf("DO%0d", k), dout, er[31:0]);
        check($sformatf("stall_cycles%0d", k), 32'(sc[k]), {24'b0, er[39:32]});
      end
      sc[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!R) begin
      sc[0] = 0;
      sc[1] = 0;
    end else begin
      mon(0, ram_E0, ram_RW0, ram_A0, ram_DI0, done0, DO0, stall0);
      mon(1, ram_E1, ram_RW1, ram_A1, ram_DI1, done1, DO1, stall1);
    end
  end

  task automatic idle(input int n);
    E = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request, scramble inputs once latched, return in the DONE cycle.
  task automatic issue(input bit rw, input bit size, input bit [7:0] a, input bit [31:0] di);
    int n;
    model(0, rw, size, a, di, 4);
    model(1, rw, size, a, di, 4);
    nops++;
    E = 1'b1; RW = rw; Size = size; A = a; DI = di;
    n = 0;
    while (!ram_E0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ram_E0) check("start_timeout", 32'd0, 32'd1);
    E = 1'b0; RW = 1'($urandom); A = 8'($urandom); DI = $urandom;
    n = 0;
    while (!done0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, {30'b0, stall1, stall0}, 32'd0);
    check({tag, "_done"},  {30'b0, done1, done0}, 32'd0);
    check({tag, "_ramE"},  {28'b0, ram_RW1, ram_RW0, ram_E1, ram_E0}, 32'd0);
    check({tag, "_ramA"},  {16'b0, ram_A1, ram_A0}, 32'd0);
    check({tag, "_ramDI"}, {16'b0, ram_DI1, ram_DI0}, 32'd0);
    check({tag, "_DO0"},   DO0, 32'd0);
    check({tag, "_DO1"},   DO1, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i]  = 8'($urandom);
      mem1[i]  = mem0[i];
      rm[0][i] = mem0[i];
      rm[1][i] = mem0[i];
    end
    ref_do[0] = 0;
    ref_do[1] = 0;
    R = 1'b0; E = 1'b0; RW = 1'b0; Size = 1'b0; A = 8'h00; DI = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    R = 1'b1;
    idle(2);
    check_idle_outputs("idle");

    issue(1'b1, 1'b1, 8'h05, 32'hDEADBEEF); idle(1);
    issue(1'b0, 1'b1, 8'h04, 32'h0);        idle(2);
    issue(1'b1, 1'b0, 8'h09, 32'h0000008C); idle(1);
    issue(1'b0, 1'b0, 8'h09, 32'h0);        idle(1);
    issue(1'b1, 1'b0, 8'h0A, 32'h12345678);
    issue(1'b0, 1'b0, 8'h09, 32'h0);
    issue(1'b1, 1'b1, 8'hFE, 32'hCAFEF00D);
    issue(1'b0, 1'b1, 8'hFE, 32'h0);
    issue(1'b0, 1'b1, 8'h04, 32'h0);        idle(1);

    for (int t = 0; t < 60; t++) begin
      idle($urandom_range(0, 2));
      issue(1'($urandom), 1'($urandom), 8'($urandom), $urandom);
    end
    idle(2);

    // Reset after the second byte of a word store: two bytes land, then everything returns to idle.
    model(0, 1'b1, 1'b1, 8'h41, 32'hA1B2C3D4, 2);
    model(1, 1'b1, 1'b1, 8'h41, 32'hA1B2C3D4, 2);
    E = 1'b1; RW = 1'b1; Size = 1'b1; A = 8'h41; DI = 32'hA1B2C3D4;
    @(posedge clk); #1;
    E = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    R = 1'b0;
    ref_do[0] = 0;
    ref_do[1] = 0;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    R = 1'b1;
    idle(2);
    check("midreset_mem0_41", {24'b0, mem0[8'h41]}, {24'b0, rm[0][8'h41]});
    check("midreset_mem0_42", {24'b0, mem0[8'h42]}, {24'b0, rm[0][8'h42]});
    check("midreset_mem1_43", {24'b0, mem1[8'h43]}, {24'b0, rm[1][8'h43]});
    check("midreset_mem1_44", {24'b0, mem1[8'h44]}, {24'b0, rm[1][8'h44]});

    issue(1'b0, 1'b1, 8'h40, 32'h0);
    idle(3);

    check("done_count0", 32'(dc[0]), 32'(nops));
    check("done_count1", 32'(dc[1]), 32'(nops));
    check("pending", 32'(qacc0.size() + qacc1.size() + qres0.size() + qres1.size()), 32'd0);
    for (int i = 0; i < 256; i++) begin
      if (mem0[i] !== rm[0][i]) check($sformatf("mem0_%0d", i), {24'b0, mem0[i]}, {24'b0, rm[0][i]});
      if (mem1[i] !== rm[1][i]) check($sformatf("mem1_%0d", i), {24'b0, mem1[i]}, {24'b0, rm[1][i]});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- MEM-stage controller between the EX_MEM register and a single-byte-port data RAM (256x8).
- Converts one load/store request (byte or word) into a sequence of byte transfers, assembles read data, and stalls the pipeline until the access completes.
- Outputs feed the MEM result mux (DO) and the hazard/forwarding logic (stall).

Parameters:
ADDR_W, 8, RAM address width; byte addresses wrap modulo 2^ADDR_W.
ALIGN_WORD, 1, when 1 word accesses force A[1:0]=00; when 0 the unaligned base is used and addresses wrap.

Ports:
clk  input  1  pipeline clock, rising edge.
R  input  1  reset; asynchronous, active-low.
E  input  1  MEM_Enable_signal: request present.
RW  input  1  1 = write (store), 0 = read (load).
Size  input  1  1 = word (4 bytes), 0 = byte.
A  input  ADDR_W  byte address from EX_MEM.
DI  input  32  store data (MEM_Pd).
ram_DO  input  8  byte read from RAM; combinational on ram_A.
ram_E  output  1  RAM byte enable.
ram_RW  output  1  RAM write strobe.
ram_A  output  ADDR_W  RAM byte address.
ram_DI  output  8  RAM write byte.
DO  output  32  assembled load data.
stall  output  1  holds PC, IF_ID, ID_EX and EX_MEM while high.
done  output  1  one-cycle pulse when an access completes.

Behaviour:
- Reset (R=0, async): state=IDLE, cnt=0, DO=0, done=0, ram_E=0, ram_RW=0, ram_A=0, ram_DI=0. Latched request registers clear.
- States: IDLE, XFER, DONE. Two-bit byte counter cnt.
- IDLE:
  - stall = E (combinational), so the pipeline freezes in the same cycle as the request.
  - When E=1, at the clock edge: latch base address, DI, RW and Size, set cnt=0, go to XFER.
  - ram_E=0 in IDLE.
  - Base address = A & ~3 when Size=1 and ALIGN_WORD=1; otherwise A.
- XFER:
  - stall=1, ram_E=1, ram_RW=latched RW, ram_A=base+cnt (mod 2^ADDR_W).
  - Byte order is big-endian: cnt=0 is the MSB.
  - Word write: ram_DI=DI[31-8*cnt -: 8].
  - Byte write: ram_DI=DI[7:0].
  - Word read: at the edge, DO[31-8*cnt -: 8] <= ram_DO.
  - Byte read: at the edge, DO <= {24'b0, ram_DO} (zero-extend).
  - Last byte is cnt==3 for a word, cnt==0 for a byte. After the last byte go to DONE; otherwise cnt++.
- DONE:
  - stall=0, done=1, ram_E=0.
  - DO is valid and the pipeline advances on this edge.
  - Unconditional transition to IDLE. E is not sampled in DONE; the next request is taken in the following IDLE cycle.
- Latency (stall-high cycles): byte access 2, word access 5. done is asserted in the 3rd / 6th cycle after the request appears.
- DO holds the last read result through writes and idle cycles. It changes only on read byte captures or reset.
- Inputs are ignored after latching: changes to A, DI or RW during XFER have no effect.
- RW=1: DO is unchanged and no capture occurs.
- Reset mid-XFER: immediate return to IDLE with ram_E=0. Bytes already written stay written; no further bytes are written. DO=0.
- E=0 in IDLE: stall=0, done=0, outputs idle.

Test Plan:
1. Reset with R=0 at t=0, release -> all outputs 0, state IDLE, stall=0.
2. Word store: E=1, RW=1, Size=1, A=0x05, DI=0xDEADBEEF -> ram_A sequence 0x04,0x05,0x06,0x07; ram_DI sequence DE,AD,BE,EF; stall high 5 cycles; done pulses once.
3. Word load: RAM[0x04..0x07] = DE,AD,BE,EF; E=1, RW=0, Size=1, A=0x04 -> DO=0xDEADBEEF in the DONE cycle; stall 5 cycles.
4. Byte load: RAM[0x09]=0x8C; E=1, RW=0, Size=0, A=0x09 -> DO=0x0000008C; stall 2 cycles. Byte store of DI=0x12345678 at A=0x0A -> single write of 0x78 to 0x0A.
5. Back-to-back requests (E held high with a new request after DONE) -> exactly one IDLE cycle between operations, with stall high in that cycle. ALIGN_WORD=0 word access at A=0xFE -> ram_A sequence 0xFE,0xFF,0x00,0x01.
6. R=0 pulsed after the 2nd byte of a word store -> only 2 bytes are written, state returns to IDLE, DO=0, stall=0, no done pulse.
